adder_sequencer: RTL and testbench

Parametrised operand-sequencing controller for the switch-and-key adder datapath. It captures NUM_OPERANDS operands of WIDTH bits, one per key press, and accumulates each with add or subtract. It then holds the result for display until the next key press. It sits between the debounced key/switch inputs and the seven-segment display mux, and supersedes the fixed two-operand, 2-bit-state controller.

---
 rtl/adder_seq_pkg.sv | 15 +
 rtl/key_edge_detect.sv | 24 ++
 rtl/adder_sequencer.sv | 130 +++++++++++++
 tb/tb_adder_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types for the operand-sequencing adder controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ADD  = 2'b10,
    SHOW = 2'b11
  } state_t;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the debounced key level.
// Latency: edge_o is combinational from level_i against the previous-cycle level.
// Backpressure: none; one pulse per low-to-high transition.
module key_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic edge_o
);

  logic level_q;

  // Previous key level; resets high so a key held through reset is not seen as a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level_i;
    end
  end

  assign edge_o = level_i & ~level_q;

endmodule

// File: rtl/adder_sequencer.sv
// Operand-sequencing controller: captures NUM_OPERANDS operands per key press and add/sub accumulates them.
// Latency: state changes on the edge after a key rise; ADD lasts one cycle; result shown 2 cycles after the last key edge.
// Backpressure: none; key edges arriving during ADD are ignored, clear always wins.
module adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter  int WIDTH        = 4,
  parameter  int NUM_OPERANDS = 3,
  localparam int SUM_W        = WIDTH + $clog2(NUM_OPERANDS),
  localparam int IDX_W        = ($clog2(NUM_OPERANDS) > 1) ? $clog2(NUM_OPERANDS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               kout,
  input  logic [WIDTH-1:0]   operand,
  input  logic               sub,
  input  logic               clear,
  output logic [SUM_W-1:0]   disp,
  output logic               select,
  output logic               load,
  output logic [IDX_W-1:0]   idx,
  output logic               done,
  output logic               ovf,
  output logic [STATE_W-1:0] state
);

  localparam int             PAD_W    = SUM_W - WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic               sub_q, sub_d;
  logic               key_edge;
  logic [SUM_W-1:0]   op_ext;

  key_edge_detect u_key_edge (
    .clk_i   (clock),
    .rst_i   (reset),
    .level_i (kout),
    .edge_o  (key_edge)
  );

  assign op_ext = {{PAD_W{1'b0}}, op_q};

  // State, accumulator, index, borrow flag and captured operand registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      sub_q   <= sub_d;
    end
  end

  // Next-state logic: key edges step the sequence, ADD applies the captured operand.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    sub_d   = sub_q;

    unique case (state_q)
      IDLE: begin
        if (key_edge) state_d = LOAD;
      end
      LOAD: begin
        if (key_edge) begin
          op_d    = operand;
          sub_d   = sub;
          state_d = ADD;
        end
      end
      ADD: begin
        if (sub_q) begin
          acc_d = acc_q - op_ext;
          // Borrow is sticky for the rest of the sequence.
          if (op_ext > acc_q) ovf_d = 1'b1;
        end else begin
          acc_d = acc_q + op_ext;
        end
        if (idx_q == LAST_IDX) begin
          state_d = SHOW;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      SHOW: begin
        if (key_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides any pending key step or ADD update.
    if (clear) state_d = IDLE;

    // Everything heading into (or sitting in) IDLE starts the next sequence clean.
    if (state_d == IDLE) begin
      acc_d = '0;
      idx_d = '0;
      ovf_d = 1'b0;
    end
  end

  // Outputs decode registered state only; operand feeds disp directly outside SHOW.
  always_comb begin
    select = (state_q == SHOW);
    done   = (state_q == SHOW);
    load   = (state_q == ADD);
    disp   = (state_q == SHOW) ? acc_q : {{PAD_W{1'b0}}, operand};
    idx    = idx_q;
    ovf    = ovf_q;
    state  = state_q;
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed bench for adder_sequencer: narrow (4-bit, 3 operands) and wide (8-bit, 4 operands) instances.
// Latency: expectations sampled 1 time unit after the active edge.
// Backpressure: n/a.
module tb_adder_sequencer;

  logic       clock;
  logic       reset;
  logic       kout;
  logic [3:0] operand;
  logic       sub;
  logic       clear;
  logic [5:0] disp;
  logic       select, load, done, ovf;
  logic [1:0] idx;
  logic [1:0] state;

  logic [7:0] w_operand;
  logic [9:0] w_disp;
  logic       w_select, w_load, w_done, w_ovf;
  logic [1:0] w_idx;
  logic [1:0] w_state;

  int n_tests = 0;
  int n_fail  = 0;
  int load_cnt = 0;
  int lc0;

  adder_sequencer #(.WIDTH(4), .NUM_OPERANDS(3)) dut (
    .clock(clock), .reset(reset), .kout(kout), .operand(operand), .sub(sub), .clear(clear),
    .disp(disp), .select(select), .load(load), .idx(idx), .done(done), .ovf(ovf), .state(state)
  );

  adder_sequencer #(.WIDTH(8), .NUM_OPERANDS(4)) dut_w (
    .clock(clock), .reset(reset), .kout(kout), .operand(w_operand), .sub(sub), .clear(clear),
    .disp(w_disp), .select(w_select), .load(w_load), .idx(w_idx), .done(w_done), .ovf(w_ovf),
    .state(w_state)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (load) load_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One key press: level high for one edge, low for the next.
  task automatic press(input logic [3:0] op, input logic s);
    operand = op;
    sub     = s;
    kout    = 1'b1;
    tick();
    kout    = 1'b0;
    tick();
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; kout = 1'b0; operand = 4'd6; sub = 1'b0; clear = 1'b0;
    w_operand = 8'd0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_state",  32'(state),  0);
    check("rst_load",   32'(load),   0);
    check("rst_select", 32'(select), 0);
    check("rst_done",   32'(done),   0);
    check("rst_ovf",    32'(ovf),    0);
    check("rst_idx",    32'(idx),    0);
    check("rst_disp",   32'(disp),   6);
    tick();

    // Add sequence 5 + 7 + 9
    press(4'd0, 1'b0);
    check("add_to_load", 32'(state), 1);
    operand = 4'd11;
    #1;
    check("load_live_disp", 32'(disp), 11);
    lc0 = load_cnt;
    press(4'd5, 1'b0);
    check("add_idx1", 32'(idx), 1);
    press(4'd7, 1'b0);
    press(4'd9, 1'b0);
    check("add_state",  32'(state),  3);
    check("add_disp",   32'(disp),   21);
    check("add_select", 32'(select), 1);
    check("add_done",   32'(done),   1);
    check("add_ovf",    32'(ovf),    0);
    check("add_loads",  32'(load_cnt - lc0), 3);
    press(4'd0, 1'b0);
    check("add_back_idle", 32'(state), 0);

    // Borrow: 3 - 5 + 0 = 62 mod 64
    press(4'd0, 1'b0);
    press(4'd3, 1'b0);
    press(4'd5, 1'b1);
    check("brw_ovf_mid", 32'(ovf), 1);
    press(4'd0, 1'b0);
    check("brw_state", 32'(state), 3);
    check("brw_disp",  32'(disp),  62);
    check("brw_ovf",   32'(ovf),   1);
    press(4'd0, 1'b0);
    check("brw_idle",     32'(state), 0);
    check("brw_ovf_clr",  32'(ovf),   0);

    // Clear beats a simultaneous key edge in LOAD with idx=1
    press(4'd0, 1'b0);
    press(4'd5, 1'b0);
    check("clr_pre_idx", 32'(idx), 1);
    clear = 1'b1; kout = 1'b1;
    tick();
    check("clr_state", 32'(state), 0);
    check("clr_idx",   32'(idx),   0);
    check("clr_load",  32'(load),  0);
    clear = 1'b0; kout = 1'b0;
    tick();
    press(4'd0, 1'b0);
    press(4'd1, 1'b0);
    press(4'd2, 1'b0);
    press(4'd3, 1'b0);
    check("clr_acc_fresh", 32'(disp), 6);
    press(4'd0, 1'b0);

    // Key held through reset produces no edge until re-pressed
    kout = 1'b1; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("held_idle", 32'(state), 0);
    kout = 1'b0; tick();
    kout = 1'b1; tick();
    check("held_repress", 32'(state), 1);
    kout = 1'b0; clear = 1'b1; tick();
    clear = 1'b0; tick();

    // Reset during ADD discards the update
    press(4'd0, 1'b0);
    press(4'd4, 1'b0);
    operand = 4'd6; kout = 1'b1;
    tick();
    check("mrst_in_add", 32'(state), 2);
    check("mrst_load",   32'(load),  1);
    reset = 1'b1; kout = 1'b0;
    tick();
    check("mrst_state", 32'(state), 0);
    check("mrst_idx",   32'(idx),   0);
    check("mrst_ovf",   32'(ovf),   0);
    check("mrst_load0", 32'(load),  0);
    check("mrst_disp",  32'(disp),  6);
    reset = 1'b0;
    tick();
    press(4'd0, 1'b0);
    press(4'd1, 1'b0);
    press(4'd1, 1'b0);
    press(4'd1, 1'b0);
    check("mrst_acc", 32'(disp), 3);

    // Wide configuration: 4 x 255
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    press(4'd0, 1'b0);
    check("wide_load", 32'(w_state), 1);
    w_operand = 8'd255;
    press(4'd0, 1'b0);
    press(4'd0, 1'b0);
    press(4'd0, 1'b0);
    check("wide_idx3", 32'(w_idx), 3);
    press(4'd0, 1'b0);
    check("wide_state", 32'(w_state), 3);
    check("wide_disp",  32'(w_disp),  1020);
    check("wide_ovf",   32'(w_ovf),   0);
    check("wide_done",  32'(w_done),  1);
    press(4'd0, 1'b0);
    check("wide_idle", 32'(w_state), 0);
    check("wide_idx0", 32'(w_idx),   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
